// File: rtl/fht_control_param_pkg.sv
// Shared types and helpers for the FHT stage/sector controller.
// Stage length, sector length and bit-reverse live here for reuse.
package fht_control_param_pkg;

    localparam int A_BIT_DEF     = 8;
    localparam int LOG_N_MIN_DEF = 4;
    localparam int PIPE_DEF      = 3;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    function automatic int stage_len(input logic [4:0] lgn, input int pipe);
        return (1 << (lgn - 5'd2)) + pipe;
    endfunction

    // log2 of sector length; never below 1 so a sector has two halves
    function automatic logic [4:0] sec_log2(input logic [4:0] k,
                                            input logic [4:0] lgn);
        logic [4:0] b;
        b = lgn - 5'd2;
        if (k < 5'd2) return b;
        if ((k - 5'd1) >= b) return 5'd1;
        return b - (k - 5'd1);
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = {<<{x}};
        return r >> (32 - n);
    endfunction

endpackage

// File: rtl/fht_control_param_if.sv
// Control/address bundle between the FHT controller and its datapath.
// master drives start/abort, slave (controller) drives the rest.
interface fht_control_param_if
    import fht_control_param_pkg::*;
#(
    parameter int A_BIT = A_BIT_DEF
);
    logic             iSTART;
    logic [4:0]       iLOG_N;
    logic             iABORT;
    logic             oRDY;
    logic             oDONE;
    logic             oERR;
    logic [4:0]       oSTAGE;
    logic             oST_ZERO;
    logic             oST_LAST;
    logic             o2ND_PART_SUBSEC;
    logic [A_BIT:0]   oSECTOR;
    logic [A_BIT-1:0] oADDR_RD_EVEN;
    logic [A_BIT-1:0] oADDR_RD_ODD;
    logic [A_BIT-1:0] oADDR_WR_0;
    logic [A_BIT-1:0] oADDR_WR_1;
    logic [A_BIT-1:0] oADDR_COEF;
    logic             oWE_A;
    logic             oWE_B;
    logic             oSOURCE_DATA;

    modport master (
        output iSTART, iLOG_N, iABORT,
        input  oRDY, oDONE, oERR, oSTAGE, oST_ZERO, oST_LAST,
        input  o2ND_PART_SUBSEC, oSECTOR,
        input  oADDR_RD_EVEN, oADDR_RD_ODD, oADDR_WR_0, oADDR_WR_1,
        input  oADDR_COEF, oWE_A, oWE_B, oSOURCE_DATA
    );

    modport slave (
        input  iSTART, iLOG_N, iABORT,
        output oRDY, oDONE, oERR, oSTAGE, oST_ZERO, oST_LAST,
        output o2ND_PART_SUBSEC, oSECTOR,
        output oADDR_RD_EVEN, oADDR_RD_ODD, oADDR_WR_0, oADDR_WR_1,
        output oADDR_COEF, oWE_A, oWE_B, oSOURCE_DATA
    );

endinterface

// File: rtl/fht_control_param_addr_gen.sv
// Per-stage sector/offset decode and bank read/write address generation.
// Write side replays the read-side sector split PIPE cycles later.
module fht_addr_gen
    import fht_control_param_pkg::*;
#(
    parameter int A_BIT = A_BIT_DEF,
    parameter int PIPE  = PIPE_DEF,
    parameter int TW    = A_BIT + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [4:0]       k_i,
    input  logic [4:0]       lgn_i,
    input  logic [TW-1:0]    t_i,
    output logic             wr_win_o,
    output logic             part2_o,
    output logic [A_BIT:0]   sector_o,
    output logic [A_BIT-1:0] rd_even_o,
    output logic [A_BIT-1:0] rd_odd_o,
    output logic [A_BIT-1:0] wr0_o,
    output logic [A_BIT-1:0] wr1_o,
    output logic [A_BIT-1:0] coef_o
);

    logic [TW-1:0]    d, sl, half, msk, s, off, odd;
    logic [TW-1:0]    w, woff, wa0, wa1;
    logic [4:0]       lsl;
    logic             rd_win, edge_k;
    logic [A_BIT-1:0] coef_q, coef_d;

    always_comb begin
        d    = TW'(1) << (lgn_i - 5'd2);
        lsl  = sec_log2(k_i, lgn_i);
        sl   = TW'(1) << lsl;
        half = sl >> 1;
        msk  = sl - TW'(1);
        s    = t_i >> lsl;
        off  = t_i & msk;

        rd_win = run_i & (t_i < d);
        // reflected sector base: nsec-s sectors of sl words = d - s*sl
        odd    = (s == '0) ? off : (d - (t_i & ~msk) + off);

        w        = t_i - TW'(PIPE);
        woff     = w & msk;
        wr_win_o = run_i & (t_i >= TW'(PIPE)) & (w < d);
        edge_k   = (k_i == 5'd0) | (k_i == (lgn_i - 5'd1));
        wa0      = w;
        wa1      = w;
        if (!edge_k) begin
            if (woff < half) wa1 = (w + half) & (d - TW'(1));
            else             wa0 = (w - half) & (d - TW'(1));
        end

        rd_even_o = rd_win ? A_BIT'(t_i) : '0;
        rd_odd_o  = rd_win ? A_BIT'(odd) : '0;
        sector_o  = rd_win ? (A_BIT+1)'(s) : '0;
        part2_o   = rd_win & (k_i >= 5'd2) & (off >= half);
        wr0_o     = wr_win_o ? A_BIT'(wa0) : '0;
        wr1_o     = wr_win_o ? A_BIT'(wa1) : '0;

        coef_d = (rd_win & (k_i >= 5'd2)) ?
                 A_BIT'(bitrev(32'(s), A_BIT)) : '0;
        coef_o = run_i ? coef_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) coef_q <= '0;
        else       coef_q <= coef_d;
    end

endmodule

// File: rtl/fht_control_param.sv
// FHT controller: run FSM, stage/time counters, handshake and write enables.
// Address decode is delegated to fht_addr_gen.
module fht_control_param
    import fht_control_param_pkg::*;
#(
    parameter int A_BIT     = A_BIT_DEF,
    parameter int LOG_N_MIN = LOG_N_MIN_DEF,
    parameter int PIPE      = PIPE_DEF,
    parameter int SEC_BIT   = A_BIT + 1
) (
    input logic               iCLK,
    input logic               iRESET,
    fht_control_param_if.slave bus
);

    localparam int         TW   = $clog2((2**A_BIT) + PIPE);
    localparam logic [4:0] LMAX = 5'(A_BIT + 2);
    localparam logic [4:0] LMIN = 5'(LOG_N_MIN);

    state_e             state_q, state_d;
    logic [4:0]         k_q, k_d, l_q, l_d;
    logic [TW-1:0]      t_q, t_d, t_end;
    logic               done_q, done_d, err_q, err_d;
    logic               run, wr_win;
    logic [SEC_BIT-1:0] sector;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            t_q     <= '0;
            l_q     <= LMAX;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            l_q     <= l_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        l_d     = l_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        t_end   = TW'(stage_len(l_q, PIPE) - 1);
        unique case (state_q)
            S_IDLE: begin
                if (bus.iSTART) begin
                    if (bus.iLOG_N >= LMIN && bus.iLOG_N <= LMAX) begin
                        state_d = S_RUN;
                        l_d     = bus.iLOG_N;
                        k_d     = '0;
                        t_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // abort takes priority over a coincident stage end
                if (bus.iABORT) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    t_d     = '0;
                end else if (t_q == t_end) begin
                    t_d = '0;
                    if (k_q == (l_q - 5'd1)) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    fht_addr_gen #(
        .A_BIT (A_BIT),
        .PIPE  (PIPE),
        .TW    (TW)
    ) u_addr (
        .clk_i     (iCLK),
        .rst_i     (iRESET),
        .run_i     (run),
        .k_i       (k_q),
        .lgn_i     (l_q),
        .t_i       (t_q),
        .wr_win_o  (wr_win),
        .part2_o   (bus.o2ND_PART_SUBSEC),
        .sector_o  (sector),
        .rd_even_o (bus.oADDR_RD_EVEN),
        .rd_odd_o  (bus.oADDR_RD_ODD),
        .wr0_o     (bus.oADDR_WR_0),
        .wr1_o     (bus.oADDR_WR_1),
        .coef_o    (bus.oADDR_COEF)
    );

    assign run              = (state_q == S_RUN);
    assign bus.oRDY         = (state_q == S_IDLE);
    assign bus.oDONE        = done_q;
    assign bus.oERR         = err_q;
    assign bus.oSTAGE       = k_q;
    assign bus.oST_ZERO     = run & (k_q == 5'd0);
    assign bus.oST_LAST     = run & (k_q == (l_q - 5'd1));
    assign bus.oSECTOR      = sector;
    assign bus.oSOURCE_DATA = run & k_q[0];
    assign bus.oWE_A        = wr_win & k_q[0];
    assign bus.oWE_B        = wr_win & ~k_q[0];

endmodule

// File: tb/tb_fht_control_param.sv
// Self-checking bench for fht_control_param (A_BIT=8, PIPE=3).
// Handshake table plus cycle-accurate scoreboard of all outputs.
module tb_fht_control_param;

    localparam int AB   = 8;
    localparam int PIPE = 3;
    localparam int LMIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fht_control_param_if #(.A_BIT(AB)) bus();

    fht_control_param #(
        .A_BIT     (AB),
        .LOG_N_MIN (LMIN),
        .PIPE      (PIPE)
    ) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic       rdy, done, err;
        logic [4:0] stage;
        logic       zero, last, part2;
        logic [8:0] sector;
        logic [7:0] rde, rdo, wr0, wr1, coef;
        logic       wea, web, src;
    } out_t;

    typedef struct {
        bit r, st;
        int ln;
        bit ab;
        bit rdy, err, wea, web;
    } vec_t;

    out_t q[$];
    int   vec = 0;
    int   bad = 0;

    bit m_run, m_done, m_err;
    int m_L, m_k, m_t, m_coef;

    function automatic int bitrev8(input int x);
        int r = 0;
        for (int i = 0; i < 8; i++) if (x[i]) r |= 1 << (7 - i);
        return r;
    endfunction

    function automatic int sec_len(input int L, input int k);
        int D = 1 << (L - 2);
        int sl = (k < 2) ? D : (D >> (k - 1));
        return (sl < 2) ? 2 : sl;
    endfunction

    function automatic out_t exp_now();
        out_t e;
        int D, sl, nsec, s, off, w, wo;
        e = '0;
        e.rdy  = !m_run;
        e.done = m_done;
        e.err  = m_err;
        if (m_run) begin
            D    = 1 << (m_L - 2);
            sl   = sec_len(m_L, m_k);
            nsec = D / sl;
            e.stage = 5'(m_k);
            e.zero  = (m_k == 0);
            e.last  = (m_k == m_L - 1);
            e.src   = (m_k % 2 == 1);
            e.coef  = 8'(m_coef);
            if (m_t < D) begin
                s = m_t / sl;
                off = m_t % sl;
                e.rde    = 8'(m_t);
                e.rdo    = 8'(((s == 0) ? 0 : nsec - s) * sl + off);
                e.part2  = (m_k >= 2) && (off >= sl / 2);
                e.sector = 9'(s);
            end
            if (m_t >= PIPE && m_t < PIPE + D) begin
                w = m_t - PIPE;
                e.wea = (m_k % 2 == 1);
                e.web = (m_k % 2 == 0);
                if (m_k == 0 || m_k == m_L - 1) begin
                    e.wr0 = 8'(w);
                    e.wr1 = 8'(w);
                end else begin
                    wo = w % sl;
                    if (wo < sl / 2) begin
                        e.wr0 = 8'(w);
                        e.wr1 = 8'((w + sl / 2) % D);
                    end else begin
                        e.wr0 = 8'(w - sl / 2);
                        e.wr1 = 8'(w);
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic model_step(input bit r, input bit st, input int ln,
                              input bit ab);
        int D, nc;
        if (r) begin
            m_run = 0; m_L = AB + 2; m_k = 0; m_t = 0;
            m_done = 0; m_err = 0; m_coef = 0;
            return;
        end
        D  = 1 << (m_L - 2);
        nc = 0;
        if (m_run && m_t < D && m_k >= 2)
            nc = bitrev8(m_t / sec_len(m_L, m_k));
        m_coef = nc;
        m_done = 0;
        m_err  = 0;
        if (!m_run) begin
            if (st) begin
                if (ln >= LMIN && ln <= AB + 2) begin
                    m_run = 1; m_L = ln; m_k = 0; m_t = 0;
                end else m_err = 1;
            end
        end else if (ab) begin
            m_run = 0; m_k = 0; m_t = 0;
        end else if (m_t == D + PIPE - 1) begin
            m_t = 0;
            if (m_k == m_L - 1) begin
                m_run = 0; m_k = 0; m_done = 1;
            end else m_k++;
        end else m_t++;
    endtask

    function automatic out_t get_dut();
        out_t g;
        g.rdy = bus.oRDY; g.done = bus.oDONE; g.err = bus.oERR;
        g.stage = bus.oSTAGE; g.zero = bus.oST_ZERO; g.last = bus.oST_LAST;
        g.part2 = bus.o2ND_PART_SUBSEC; g.sector = bus.oSECTOR;
        g.rde = bus.oADDR_RD_EVEN; g.rdo = bus.oADDR_RD_ODD;
        g.wr0 = bus.oADDR_WR_0; g.wr1 = bus.oADDR_WR_1;
        g.coef = bus.oADDR_COEF;
        g.wea = bus.oWE_A; g.web = bus.oWE_B; g.src = bus.oSOURCE_DATA;
        return g;
    endfunction

    task automatic chk_out(input string tag, input out_t g, input out_t e);
        vec++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (k=%0d t=%0d)",
                     tag, g, e, m_k, m_t);
        end
    endtask

    task automatic chk_int(input string tag, input int g, input int e);
        vec++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, g, e);
        end
    endtask

    task automatic cyc(input bit r, input bit st, input int ln,
                       input bit ab, input string tag);
        out_t g, e;
        rst = r;
        bus.iSTART = st;
        bus.iLOG_N = 5'(ln);
        bus.iABORT = ab;
        model_step(r, st, ln, ab);
        q.push_back(exp_now());
        @(posedge clk);
        #1;
        g = get_dut();
        e = q.pop_front();
        chk_out(tag, g, e);
    endtask

    vec_t tv[14];
    out_t zr;
    int n, ca, cb, dn;

    initial begin
        bus.iSTART = 0; bus.iLOG_N = 0; bus.iABORT = 0;
        tv[0]  = '{1, 0,  0, 0, 1, 0, 0, 0};
        tv[1]  = '{0, 1, 11, 0, 1, 1, 0, 0};
        tv[2]  = '{0, 0,  0, 0, 1, 0, 0, 0};
        tv[3]  = '{0, 1,  3, 0, 1, 1, 0, 0};
        tv[4]  = '{0, 0,  0, 1, 1, 0, 0, 0};
        tv[5]  = '{0, 1, 12, 0, 1, 1, 0, 0};
        tv[6]  = '{0, 1,  4, 0, 0, 0, 0, 0};
        tv[7]  = '{0, 1, 11, 0, 0, 0, 0, 0};
        tv[8]  = '{0, 0,  0, 0, 0, 0, 0, 0};
        tv[9]  = '{0, 0,  0, 0, 0, 0, 0, 1};
        tv[10] = '{0, 0,  0, 1, 1, 0, 0, 0};
        tv[11] = '{0, 1, 10, 0, 0, 0, 0, 0};
        tv[12] = '{1, 1, 10, 0, 1, 0, 0, 0};
        tv[13] = '{0, 0,  0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(tv[i].r, tv[i].st, tv[i].ln, tv[i].ab, $sformatf("tv%0d", i));
            chk_int($sformatf("tv%0d rdy/err/we", i),
                    {bus.oRDY, bus.oERR, bus.oWE_A, bus.oWE_B},
                    {tv[i].rdy, tv[i].err, tv[i].wea, tv[i].web});
        end

        // full L=10 transform
        cyc(0, 1, 10, 0, "start10");
        n = 1; ca = 0; cb = 0;
        while (!bus.oDONE && n < 3000) begin
            cyc(0, 0, 0, 0, "run10");
            n++;
            ca += bus.oWE_A;
            cb += bus.oWE_B;
            if (m_run && m_k == 3) begin
                if (m_t == 1)   chk_int("coef s0", bus.oADDR_COEF, 0);
                if (m_t == 65)  chk_int("coef s1", bus.oADDR_COEF, 128);
                if (m_t == 129) chk_int("coef s2", bus.oADDR_COEF, 64);
                if (m_t == 193) chk_int("coef s3", bus.oADDR_COEF, 192);
            end
        end
        chk_int("done cycle L10", n, 2591);
        chk_int("weA cycles L10", ca, 1280);
        chk_int("weB cycles L10", cb, 1280);

        // L=6 sector decode corner
        cyc(0, 1, 6, 0, "start6");
        n = 1;
        while (!bus.oDONE && n < 500) begin
            cyc(0, 0, 0, 0, "run6");
            n++;
            if (m_run && m_k == 2 && m_t == 9) begin
                chk_int("L6 rd_odd t9", bus.oADDR_RD_ODD, 9);
                chk_int("L6 sector t9", bus.oSECTOR, 1);
                chk_int("L6 part2 t9", bus.o2ND_PART_SUBSEC, 0);
            end
            if (m_run && m_k == 2 && m_t == 13)
                chk_int("L6 part2 t13", bus.o2ND_PART_SUBSEC, 1);
        end
        chk_int("done cycle L6", n, 6 * 19 + 1);

        // abort at stage 4 t=100
        cyc(0, 1, 10, 0, "start abort");
        n = 0;
        while (!(m_run && m_k == 4 && m_t == 100) && n < 3000) begin
            cyc(0, 0, 0, 0, "pre abort");
            n++;
        end
        cyc(0, 0, 0, 1, "abort");
        chk_int("abort rdy/we", {bus.oRDY, bus.oWE_A, bus.oWE_B}, 3'b100);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, "post abort");
            dn += bus.oDONE;
        end
        chk_int("done after abort", dn, 0);
        cyc(0, 1, 5, 0, "start5");
        n = 1;
        while (!bus.oDONE && n < 500) begin
            cyc(0, 0, 0, 0, "run5");
            n++;
        end
        chk_int("done cycle L5", n, 5 * 11 + 1);

        // reset mid-stage 3 with concurrent start
        cyc(0, 1, 6, 0, "start rst");
        n = 0;
        while (!(m_run && m_k == 3 && m_t == 5) && n < 500) begin
            cyc(0, 0, 0, 0, "pre rst");
            n++;
        end
        cyc(1, 1, 6, 0, "rst mid");
        zr = '0;
        zr.rdy = 1'b1;
        chk_out("rst values", get_dut(), zr);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0, 0, "post rst");
            dn += bus.oDONE;
        end
        chk_int("done after rst", dn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/fht_control_param.md
FHT_CONTROL_PARAM -- requirements
Module: fht_control_param

Interface
REQ-001 Parameter A_BIT, default 8: bank address width; max bank depth DMAX = 2^A_BIT; max transform NMAX = 4*DMAX.
REQ-002 Parameter LOG_N_MIN, default 4: smallest accepted log2 transform size.
REQ-003 Parameter PIPE, default 3: read-to-write datapath latency in cycles (>=2).
REQ-004 Parameter SEC_BIT = A_BIT+1: sector index width.
REQ-005 iCLK  in  1  sole clock; all logic on rising edge.
REQ-006 iRESET  in  1  synchronous, active-high reset.
REQ-007 iSTART  in  1  start request, sampled only while oRDY=1.
REQ-008 iLOG_N  in  5  log2 of transform size N, sampled with iSTART.
REQ-009 iABORT  in  1  synchronous abort while running.
REQ-010 oRDY  out  1  idle, ready for iSTART.
REQ-011 oDONE  out  1  one-cycle pulse on normal completion.
REQ-012 oERR  out  1  one-cycle pulse on rejected iLOG_N.
REQ-013 oSTAGE  out  5  current stage k, 0..S-1.
REQ-014 oST_ZERO / oST_LAST  out  1 each  k==0 while running / k==S-1.
REQ-015 o2ND_PART_SUBSEC  out  1  second half of current sector (k>=2).
REQ-016 oSECTOR  out  SEC_BIT  current sector index s.
REQ-017 oADDR_RD_EVEN / oADDR_RD_ODD  out  A_BIT each  read address, banks 0,2 / banks 1,3.
REQ-018 oADDR_WR_0 / oADDR_WR_1  out  A_BIT each  write address, banks 0,1 / banks 2,3.
REQ-019 oADDR_COEF  out  A_BIT  twiddle ROM address.
REQ-020 oWE_A / oWE_B  out  1 each  write enable, RAM set A / set B.
REQ-021 oSOURCE_DATA  out  1  ping-pong select; toggles at each stage end.

Function
REQ-022 Sizes: D = 2^(L-2), S = L stages, L = latched iLOG_N; stage length D+PIPE cycles, stage time t = 0..D+PIPE-1.
REQ-023 FSM IDLE->RUN on iSTART with LOG_N_MIN<=iLOG_N<=A_BIT+2; stage 0 t=0 on the next cycle; oRDY low from that cycle.
REQ-024 Out-of-range iLOG_N: stay IDLE, oERR=1 next cycle, oRDY stays 1.
REQ-025 iSTART in RUN ignored; iLOG_N changes in RUN have no effect.
REQ-026 RUN->IDLE after t=D+PIPE-1 of stage S-1: oDONE=1 and oRDY=1 on the following cycle.
REQ-027 iABORT in RUN: IDLE next cycle, oRDY=1, oDONE=0, all enables 0; iABORT ignored in IDLE; iABORT wins over same-cycle stage end.
REQ-028 Sector length: sl = D for k=0,1; sl = D>>(k-1) for k>=2, floor 2; nsec = D/sl.
REQ-029 Read window t<D: s = t/sl, off = t mod sl; oADDR_RD_EVEN = t; oADDR_RD_ODD = refl(s)*sl+off, refl(0)=0, refl(s)=nsec-s; both 0 outside window.
REQ-030 o2ND_PART_SUBSEC = (k>=2) & (off>=sl/2) within read window, else 0.
REQ-031 Write window PIPE<=t<PIPE+D, w = t-PIPE: if k==0 | k==S-1 both write addresses = w; otherwise in first half of write sector oADDR_WR_0=w, oADDR_WR_1=w+sl/2, in second half oADDR_WR_0=w-sl/2, oADDR_WR_1=w; arithmetic modulo D; both 0 outside window.
REQ-032 Write sector/half derived from w exactly as REQ-029/030 derive them from t (i.e. delayed PIPE cycles).
REQ-033 oWE_A = window & k odd; oWE_B = window & k even; never both high.
REQ-034 oADDR_COEF at t+1 = bitrev_A_BIT(s at t) for t<D; 0 otherwise and for k<2.
REQ-035 oSOURCE_DATA = 0 at stage 0, toggles at each stage boundary, 0 in IDLE.
REQ-036 Stage/sector counters sized for DMAX; upper bits zero when L < A_BIT+2.

Reset
REQ-037 iRESET=1 at a rising edge: FSM IDLE, oRDY=1, every other output 0, L = A_BIT+2; overrides iSTART/iABORT; mid-run reset discards the transform with no oDONE.

Structure
REQ-038 Shared package holds FSM state encoding, stage-length and sector-length functions, bit-reverse function, default parameter constants.
REQ-039 One sub-module fht_addr_gen: per-stage sector/offset and read/write address generation; FSM, handshake and enables stay in top.

Verification
REQ-040 A_BIT=8, iLOG_N=10, pulse iSTART -> 10 stages of 259 cycles, oDONE at cycle 2591 after start, oWE_B in stages 0,2,...,8, oWE_A in 1,...,9.
REQ-041 iLOG_N=6 (D=16), stage 2, t=9 -> sl=8, s=1, off=1, oADDR_RD_ODD=1*8+1=9, o2ND_PART_SUBSEC=0; t=13 -> o2ND_PART_SUBSEC=1.
REQ-042 iLOG_N=11 or 3 with iSTART -> oERR=1 for one cycle, oRDY stays 1, no enables.
REQ-043 iABORT at stage 4 t=100 -> next cycle oRDY=1, oWE_A=oWE_B=0, oDONE never pulses; fresh iSTART then runs fully.
REQ-044 iRESET asserted mid-stage-3 concurrent with iSTART -> next cycle all outputs at reset values.
REQ-045 iLOG_N=10, stage 3 (sl=64) -> oADDR_COEF sequence 0,128,64,192 as s goes 0..3.
